// File: rtl/ram_ctrl_pkg.sv
// ============================================================================
// Module  : ram_ctrl_pkg
// Brief   : Shared widths and FSM state encoding for the RAM burst controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_ctrl_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_rd_skid.sv
// ============================================================================
// Module  : ram_rd_skid
// Brief   : 2-entry in-order valid/ready buffer; occupancy feeds read-issue credit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_rd_skid
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [1:0]        r_count;
    logic              w_pop;

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;
    assign o_count = r_count;
    assign w_pop   = o_valid & i_ready;

    // Upstream credit check guarantees no push while full without a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_data;
                    else                 r_tail <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_burst_ctrl.sv
// ============================================================================
// Module  : ram_burst_ctrl
// Brief   : Read/write burst front end for a 1K x 8 single-port registered RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_burst_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last_addr;
    logic [DATA_W-1:0] r_last_din;
    logic [LEN_W-1:0]  r_beats;
    logic              r_inflight;
    logic              w_cmd_hs;
    logic              w_wr_hs;
    logic              w_issue;
    logic              w_pop;
    logic [1:0]        w_occ;
    logic [2:0]        w_credit;

    assign w_cmd_hs = cmd_valid & cmd_ready;
    assign w_wr_hs  = wr_valid & wr_ready;
    assign w_pop    = rd_valid & rd_ready;
    // Slots committed for next cycle: buffered + in flight, less what leaves now.
    assign w_credit = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue  = (r_state == READ) && (w_credit < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_next = cmd_we ? WRITE : READ;
            WRITE:   if (w_wr_hs && (r_beats == '0)) w_next = IDLE;
            READ:    if (w_issue && (r_beats == '0)) w_next = DRAIN;
            DRAIN:   if (!r_inflight && (w_occ == 2'd0)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        wr_ready  = (r_state == WRITE);
        busy      = (r_state != IDLE);
        ram_we    = wr_valid & (r_state == WRITE);
        ram_addr  = ((r_state == WRITE) || (r_state == READ)) ? r_addr : r_last_addr;
        ram_din   = (r_state == WRITE) ? wr_data : r_last_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_last_addr <= '0;
            r_last_din  <= '0;
            r_beats     <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_cmd_hs) begin
                r_addr  <= cmd_addr;
                r_beats <= cmd_len;
            end else if (w_wr_hs || w_issue) begin
                r_addr      <= r_addr + 1'b1;
                r_beats     <= r_beats - 1'b1;
                r_last_addr <= r_addr;
            end
            if (w_wr_hs) r_last_din <= wr_data;
        end
    end

    ram_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (ram_dout),
        .o_valid (rd_valid),
        .i_ready (rd_ready),
        .o_data  (rd_data),
        .o_count (w_occ)
    );

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
// ============================================================================
// Module  : tb_ram_burst_ctrl
// Brief   : Directed scenario bench for ram_burst_ctrl with a 1K x 8 RAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic [9:0] cmd_addr = '0;
    logic [4:0] cmd_len = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = '0;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       busy;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    logic [7:0] mem [1024];
    logic [7:0] got [$];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    ram_burst_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Returns at the falling edge of the cycle after the handshake, cmd_valid dropped.
    task automatic send_cmd(input logic we, input logic [9:0] a, input logic [4:0] l);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
        #1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_handshake_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [9:0] a, input logic [4:0] l, input logic [7:0] base);
        send_cmd(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            wr_valid = 1'b1; wr_data = base + 8'(i);
            @(negedge clk);
        end
        wr_valid = 1'b0;
    endtask

    // Call at a falling edge during a read; mode 0 = always ready, 1 = ready 1,0,0 repeating.
    task automatic collect_read(input int mode);
        int k = 0;
        got.delete();
        forever begin
            rd_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            #1;
            if (rd_valid && rd_ready) got.push_back(rd_data);
            if (!busy || k >= 200) break;
            @(negedge clk);
            k++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL read_drain_timeout: busy=%b required 0", busy);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({cmd_ready, wr_ready, rd_valid, busy, ram_we} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 10000", {cmd_ready, wr_ready, rd_valid, busy, ram_we});
        end
        checks++;
        if (ram_addr !== 10'h000 || ram_din !== 8'h00) begin
            errors++;
            $display("FAIL reset_ram_port: addr=%h din=%h required 000/00", ram_addr, ram_din);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_wrap();
        logic [9:0] exp_a [4];
        exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
        send_cmd(1'b1, 10'h3FE, 5'd3);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = 8'hA0 + 8'(i);
            #1;
            checks++;
            if (ram_we !== 1'b1 || ram_addr !== exp_a[i] || ram_din !== 8'hA0 + 8'(i) || busy !== 1'b1) begin
                errors++;
                $display("FAIL write_wrap_beat%0d: we=%b addr=%h din=%h busy=%b required 1/%h/%h/1",
                         i, ram_we, ram_addr, ram_din, busy, exp_a[i], 8'hA0 + 8'(i));
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ram_we !== 1'b0 || cmd_ready !== 1'b1 || ram_addr !== 10'h001) begin
            errors++;
            $display("FAIL write_wrap_end: busy=%b we=%b cmd_ready=%b addr=%h required 0/0/1/001",
                     busy, ram_we, cmd_ready, ram_addr);
        end
        checks++;
        if (mem[10'h3FE] !== 8'hA0 || mem[10'h3FF] !== 8'hA1 || mem[10'h000] !== 8'hA2 || mem[10'h001] !== 8'hA3) begin
            errors++;
            $display("FAIL write_wrap_mem: %h %h %h %h required a0 a1 a2 a3",
                     mem[10'h3FE], mem[10'h3FF], mem[10'h000], mem[10'h001]);
        end
    endtask

    task automatic test_read_latency();
        rd_ready = 1'b1;
        send_cmd(1'b0, 10'h3FE, 5'd3);
        #1;
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== 10'h3FE || rd_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_first_issue: we=%b addr=%h rd_valid=%b busy=%b required 0/3fe/0/1",
                     ram_we, ram_addr, rd_valid, busy);
        end
        @(negedge clk); #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_n2_valid: rd_valid=%b required 0", rd_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL read_beat%0d: valid=%b data=%h required 1/%h", i, rd_valid, rd_data, 8'hA0 + 8'(i));
            end
        end
        @(negedge clk); #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_after_last: rd_valid=%b required 0", rd_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_busy_end: busy=%b cmd_ready=%b required 0/1", busy, cmd_ready);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_read_backpressure();
        write_burst(10'h100, 5'd7, 8'h10);
        send_cmd(1'b0, 10'h100, 5'd7);
        collect_read(1);
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL bp_count: beats=%0d required 8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++;
            if (got[i] !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL bp_beat%0d: data=%h required %h", i, got[i], 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_single_delayed();
        send_cmd(1'b1, 10'h055, 5'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ram_we !== 1'b0 || busy !== 1'b1 || wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_wait%0d: we=%b busy=%b wr_ready=%b required 0/1/1", i, ram_we, busy, wr_ready);
            end
            @(negedge clk);
        end
        wr_valid = 1'b1; wr_data = 8'h5A;
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 10'h055 || ram_din !== 8'h5A) begin
            errors++;
            $display("FAIL single_beat: we=%b addr=%h din=%h required 1/055/5a", ram_we, ram_addr, ram_din);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ram_we !== 1'b0 || mem[10'h055] !== 8'h5A) begin
            errors++;
            $display("FAIL single_end: busy=%b we=%b mem=%h required 0/0/5a", busy, ram_we, mem[10'h055]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h200; cmd_len = 5'd2;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_ready: cmd_ready=%b required 1", cmd_ready);
        end
        // Hold cmd_valid with a read command queued behind the write.
        @(negedge clk);
        cmd_we = 1'b0; cmd_addr = 10'h200; cmd_len = 5'd2;
        for (int c = 0; c < 4; c++) begin
            wr_valid = (c != 1);
            wr_data  = (c == 0) ? 8'hC0 : (c == 2) ? 8'hC1 : 8'hC2;
            #1;
            checks++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1 || ram_we !== (c != 1)) begin
                errors++;
                $display("FAIL b2b_hold%0d: cmd_ready=%b busy=%b we=%b required 0/1/%b",
                         c, cmd_ready, busy, ram_we, (c != 1));
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: busy=%b cmd_ready=%b required 0/1", busy, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        collect_read(0);
        checks++;
        if (got.size() != 3 || got[0] !== 8'hC0 || got[1] !== 8'hC1 || got[2] !== 8'hC2) begin
            errors++;
            $display("FAIL b2b_readback: beats=%0d required 3 of c0 c1 c2", got.size());
        end
    endtask

    task automatic test_reset_midburst();
        write_burst(10'h300, 5'd7, 8'h30);
        rd_ready = 1'b1;
        send_cmd(1'b0, 10'h300, 5'd7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || cmd_ready !== 1'b1 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b rd_valid=%b cmd_ready=%b we=%b required 0/0/1/0",
                     busy, rd_valid, cmd_ready, ram_we);
        end
        send_cmd(1'b0, 10'h300, 5'd7);
        collect_read(0);
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL rst_reread_count: beats=%0d required 8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++;
            if (got[i] !== 8'h30 + 8'(i)) begin
                errors++;
                $display("FAIL rst_reread%0d: data=%h required %h", i, got[i], 8'h30 + 8'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_wrap();
        test_read_latency();
        test_read_backpressure();
        test_single_delayed();
        test_back_to_back();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
